seq_multiplier: RTL and testbench



---
 rtl/mult_pkg.sv | 13 +
 rtl/seq_mult_datapath.sv | 86 ++++++++
 rtl/seq_multiplier.sv | 90 +++++++++
 tb/tb_seq_multiplier.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiplier: FSM encoding and operand width limits.
package mult_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } mult_state_e;

  localparam int unsigned WidthMin = 2;
  localparam int unsigned WidthMax = 32;

endpackage

// File: rtl/seq_mult_datapath.sv
// Shift-add datapath: multiplicand/multiplier shift registers, accumulator and result register.
// SEQ_MULT_SIGNED_EN adds magnitude conversion on load and sign correction on the final edge.
module seq_mult_datapath #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               finish,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
`ifdef SEQ_MULT_SIGNED_EN
  input  logic               signed_mode,
`endif
  output logic [2*WIDTH-1:0] result
);

  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] result_q;
  logic [2*WIDTH-1:0] result_d;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

`ifdef SEQ_MULT_SIGNED_EN
  logic neg_q;
  logic neg_d;

  // The most-negative value negates to itself, which reads correctly as an unsigned magnitude.
  always_comb begin
    mag_a = (signed_mode && op_a[WIDTH-1]) ? -op_a : op_a;
    mag_b = (signed_mode && op_b[WIDTH-1]) ? -op_b : op_b;
    neg_d = signed_mode && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_q <= 1'b0;
    end else if (load) begin
      neg_q <= neg_d;
    end
  end

  always_comb begin
    acc_next = mplier_q[0] ? acc_q + mcand_q : acc_q;
    result_d = neg_q ? -acc_next : acc_next;
  end
`else
  always_comb begin
    mag_a    = op_a;
    mag_b    = op_b;
    acc_next = mplier_q[0] ? acc_q + mcand_q : acc_q;
    result_d = acc_next;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (load) begin
      mcand_q  <= {{WIDTH{1'b0}}, mag_a};
      mplier_q <= mag_b;
      acc_q    <= '0;
    end else if (step) begin
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      acc_q    <= acc_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
    end else if (finish) begin
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: WIDTH-cycle latency behind a start/done handshake.
// Define SEQ_MULT_SIGNED_EN to add the signed_mode port and two's-complement support.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
`ifdef SEQ_MULT_SIGNED_EN
  input  logic               signed_mode,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  mult_state_e     state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  logic            accept;
  logic            step;
  logic            finish;

  assign accept = start && ((state_q == StIdle) || (state_q == StDone));
  assign step   = (state_q == StCalc);
  assign finish = step && (count_q == CntW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StCalc;
          count_d = CntW'(WIDTH);
        end
      end
      StCalc: begin
        busy    = 1'b1;
        count_d = count_q - CntW'(1);
        if (finish) state_d = StDone;
      end
      StDone: begin
        done = 1'b1;
        // Start in DONE is accepted directly so back-to-back products skip IDLE.
        if (accept) begin
          state_d = StCalc;
          count_d = CntW'(WIDTH);
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  seq_mult_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .step       (step),
    .finish     (finish),
    .op_a       (op_a),
    .op_b       (op_b),
`ifdef SEQ_MULT_SIGNED_EN
    .signed_mode(signed_mode),
`endif
    .result     (result)
  );

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier at WIDTH=8; signed cases run when SEQ_MULT_SIGNED_EN is set.
module tb_seq_multiplier;

  localparam int unsigned W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] result;
`ifdef SEQ_MULT_SIGNED_EN
  logic           signed_mode = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_multiplier #(
    .WIDTH(W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op_a       (op_a),
    .op_b       (op_b),
`ifdef SEQ_MULT_SIGNED_EN
    .signed_mode(signed_mode),
`endif
    .busy       (busy),
    .done       (done),
    .result     (result)
  );

  // Pulses start for one edge, then counts edges until done; lat=-1 on timeout.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 0;
    while (1) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
      if (lat >= 40) begin
        lat = -1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
    checks++;
    if (result !== 16'd0) begin failures++; $display("FAIL reset_result got=%0d want=0", result); end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    int lat;
    op_a  = 8'd2;
    op_b  = 8'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL busy_after_start got=%b want=1", busy); end
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (done !== 1'b1 || result !== 16'd6) begin
      failures++;
      $display("FAIL mul_2x3 got done=%b result=%0d want done=1 result=6", done, result);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL done_one_cycle got done=%b busy=%b want 0 0", done, busy);
    end
    run_op(8'd4, 8'd6, lat);
    checks++;
    if (lat !== 8 || result !== 16'd24) begin
      failures++;
      $display("FAIL mul_4x6 got lat=%0d result=%0d want lat=8 result=24", lat, result);
    end
    run_op(8'd3, 8'd3, lat);
    checks++;
    if (lat !== 8 || result !== 16'd9) begin
      failures++;
      $display("FAIL mul_3x3 got lat=%0d result=%0d want lat=8 result=9", lat, result);
    end
  endtask

  task automatic test_boundary();
    int lat;
    run_op(8'd255, 8'd255, lat);
    checks++;
    if (lat !== 8 || result !== 16'd65025) begin
      failures++;
      $display("FAIL mul_255x255 got lat=%0d result=%0d want lat=8 result=65025", lat, result);
    end
    run_op(8'd0, 8'd200, lat);
    checks++;
    if (lat !== 8 || result !== 16'd0) begin
      failures++;
      $display("FAIL mul_0x200 got lat=%0d result=%0d want lat=8 result=0", lat, result);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(posedge clk);
    #1;
    op_a  = 8'd2;
    op_b  = 8'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    op_a = 8'd7;
    op_b = 8'd9;
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (done !== 1'b1 || result !== 16'd6) begin
      failures++;
      $display("FAIL b2b_first got done=%b result=%0d want done=1 result=6", done, result);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_no_idle got busy=%b done=%b want 1 0", busy, done);
    end
    lat = 0;
    while (1) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
      if (lat >= 40) begin
        lat = -1;
        break;
      end
    end
    checks++;
    if (lat !== 8 || result !== 16'd63) begin
      failures++;
      $display("FAIL b2b_second got lat=%0d result=%0d want lat=8 result=63", lat, result);
    end
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 16'd63) begin
      failures++;
      $display("FAIL b2b_idle got busy=%b done=%b result=%0d want 0 0 63", busy, done, result);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    op_a  = 8'd6;
    op_b  = 8'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 16'd0) begin
      failures++;
      $display("FAIL reset_mid got busy=%b done=%b result=%0d want 0 0 0", busy, done, result);
    end
    @(posedge clk);
    #1;
    rst  = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL reset_mid_quiet got=%0d want=0", seen); end
    run_op(8'd5, 8'd5, lat);
    checks++;
    if (lat !== 8 || result !== 16'd25) begin
      failures++;
      $display("FAIL mul_5x5 got lat=%0d result=%0d want lat=8 result=25", lat, result);
    end
  endtask

  task automatic test_ignore_in_calc();
    int lat;
    op_a  = 8'd10;
    op_b  = 8'd11;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 0;
    while (1) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 3) begin
        op_a  = 8'd3;
        op_b  = 8'd3;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) break;
      if (lat >= 40) begin
        lat = -1;
        break;
      end
    end
    checks++;
    if (lat !== 8 || result !== 16'd110) begin
      failures++;
      $display("FAIL ignore_calc got lat=%0d result=%0d want lat=8 result=110", lat, result);
    end
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (result !== 16'd110 || done !== 1'b0) begin
      failures++;
      $display("FAIL result_hold got result=%0d done=%b want 110 0", result, done);
    end
  endtask

`ifdef SEQ_MULT_SIGNED_EN
  task automatic test_signed();
    int lat;
    signed_mode = 1'b1;
    run_op(8'h80, 8'h80, lat);
    checks++;
    if (lat !== 8 || result !== 16'd16384) begin
      failures++;
      $display("FAIL s_m128xm128 got lat=%0d result=%h want lat=8 result=4000", lat, result);
    end
    run_op(8'hFD, 8'd5, lat);
    checks++;
    if (lat !== 8 || result !== 16'hFFF1) begin
      failures++;
      $display("FAIL s_m3x5 got lat=%0d result=%h want lat=8 result=fff1", lat, result);
    end
    signed_mode = 1'b0;
    run_op(8'h80, 8'h80, lat);
    checks++;
    if (lat !== 8 || result !== 16'd16384) begin
      failures++;
      $display("FAIL u_80x80 got lat=%0d result=%h want lat=8 result=4000", lat, result);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_back_to_back();
    test_reset_mid();
    test_ignore_in_calc();
`ifdef SEQ_MULT_SIGNED_EN
    test_signed();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
